// File: rtl/eth_frame_detector_pkg.sv
// Shared types for the frame-detector log arbiter.
//   arb_state_e : arbiter FSM states (IDLE, FWD_A, FWD_B)
//   SRC_A/SRC_B : source ids as presented on m_axis_log_tdest
package eth_frame_detector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD_A = 2'd1,
    FWD_B = 2'd2
  } arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/eth_frame_detector_log_arbiter_axis_reg_slice.sv
// One-stage AXI4-Stream register slice carrying tdata/tdest/tlast.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   in_valid/in_ready/in_*           : upstream side (in_ready is combinational)
//   out_valid/out_ready/out_*        : registered downstream side
// in_ready = !out_valid || out_ready, so a beat can be loaded in the same
// cycle the held beat is consumed, giving one beat per cycle.
module axis_reg_slice #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dest,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_dest,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dest_q, dest_d;
  logic              last_q, last_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    dest_d  = dest_q;
    last_d  = last_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      dest_d  = in_dest;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dest_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_dest  = dest_q;
  assign out_last  = last_q;

endmodule

// File: rtl/eth_frame_detector_log_arbiter.sv
// Packet-aware round-robin merge of the two frame-detector log streams.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   enable              : permits new grants; a packet in flight always completes
//   clear_counters      : pulse, zeroes count_a/count_b (wins over an increment)
//   s_axis_log_a_*      : log stream A (AXIS slave)
//   s_axis_log_b_*      : log stream B (AXIS slave)
//   m_axis_log_*        : merged stream, tdest = source id (0 = A, 1 = B)
//   count_a, count_b    : saturating per-source packet counters
//   busy                : FSM not idle or output beat pending
//
// state | meaning
// IDLE  | no grant; arbitrate between pending sources (one bubble per packet)
// FWD_A | forwarding a packet from A until its tlast is accepted
// FWD_B | forwarding a packet from B until its tlast is accepted
module eth_frame_detector_log_arbiter
  import eth_frame_detector_pkg::*;
#(
  parameter int C_AXIS_LOG_WIDTH = 64,
  parameter int C_CNT_WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        clear_counters,
  input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_a_tdata,
  input  logic                        s_axis_log_a_tlast,
  input  logic                        s_axis_log_a_tvalid,
  output logic                        s_axis_log_a_tready,
  input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_b_tdata,
  input  logic                        s_axis_log_b_tlast,
  input  logic                        s_axis_log_b_tvalid,
  output logic                        s_axis_log_b_tready,
  output logic [C_AXIS_LOG_WIDTH-1:0] m_axis_log_tdata,
  output logic                        m_axis_log_tdest,
  output logic                        m_axis_log_tlast,
  output logic                        m_axis_log_tvalid,
  input  logic                        m_axis_log_tready,
  output logic [C_CNT_WIDTH-1:0]      count_a,
  output logic [C_CNT_WIDTH-1:0]      count_b,
  output logic                        busy
);

  arb_state_e                  state_q, state_d;
  logic                        last_grant_q, last_grant_d;
  logic [C_CNT_WIDTH-1:0]      count_a_q, count_a_d;
  logic [C_CNT_WIDTH-1:0]      count_b_q, count_b_d;

  logic                        slc_in_valid;
  logic                        slc_in_ready;
  logic [C_AXIS_LOG_WIDTH-1:0] slc_in_data;
  logic                        slc_in_dest;
  logic                        slc_in_last;

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d             = state_q;
    last_grant_d        = last_grant_q;
    count_a_d           = count_a_q;
    count_b_d           = count_b_q;
    s_axis_log_a_tready = 1'b0;
    s_axis_log_b_tready = 1'b0;
    slc_in_valid        = 1'b0;
    slc_in_data         = s_axis_log_a_tdata;
    slc_in_dest         = SRC_A;
    slc_in_last         = s_axis_log_a_tlast;

    case (state_q)
      IDLE: begin
        if (enable) begin
          // On a tie, A wins only when B was granted last.
          if (s_axis_log_a_tvalid && (!s_axis_log_b_tvalid || last_grant_q == SRC_B)) begin
            state_d      = FWD_A;
            last_grant_d = SRC_A;
          end else if (s_axis_log_b_tvalid) begin
            state_d      = FWD_B;
            last_grant_d = SRC_B;
          end
        end
      end
      FWD_A: begin
        s_axis_log_a_tready = slc_in_ready;
        slc_in_valid        = s_axis_log_a_tvalid;
        if (s_axis_log_a_tvalid && slc_in_ready && s_axis_log_a_tlast) begin
          state_d   = IDLE;
          count_a_d = sat_inc(count_a_q);
        end
      end
      FWD_B: begin
        s_axis_log_b_tready = slc_in_ready;
        slc_in_valid        = s_axis_log_b_tvalid;
        slc_in_data         = s_axis_log_b_tdata;
        slc_in_dest         = SRC_B;
        slc_in_last         = s_axis_log_b_tlast;
        if (s_axis_log_b_tvalid && slc_in_ready && s_axis_log_b_tlast) begin
          state_d   = IDLE;
          count_b_d = sat_inc(count_b_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_counters) begin
      count_a_d = '0;
      count_b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_B;
      count_a_q    <= '0;
      count_b_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      count_a_q    <= count_a_d;
      count_b_q    <= count_b_d;
    end
  end

  axis_reg_slice #(
    .DATA_W (C_AXIS_LOG_WIDTH)
  ) u_out_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (slc_in_valid),
    .in_ready  (slc_in_ready),
    .in_data   (slc_in_data),
    .in_dest   (slc_in_dest),
    .in_last   (slc_in_last),
    .out_valid (m_axis_log_tvalid),
    .out_ready (m_axis_log_tready),
    .out_data  (m_axis_log_tdata),
    .out_dest  (m_axis_log_tdest),
    .out_last  (m_axis_log_tlast)
  );

  assign count_a = count_a_q;
  assign count_b = count_b_q;
  assign busy    = (state_q != IDLE) || m_axis_log_tvalid;

endmodule

// File: tb/tb_eth_frame_detector_log_arbiter.sv
// Self-checking bench for eth_frame_detector_log_arbiter (counter width 2 so
// saturation is reachable). Cycle-exact vector table, directed corner cases,
// then randomized traffic against a queue-based reference model.
module tb_eth_frame_detector_log_arbiter;

  localparam int DW     = 64;
  localparam int CW     = 2;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, enable, clear_counters;
  logic [DW-1:0] a_data, b_data, m_data;
  logic          a_last, a_valid, a_ready;
  logic          b_last, b_valid, b_ready;
  logic          m_dest, m_last, m_valid, m_ready;
  logic [CW-1:0] count_a, count_b;
  logic          busy;

  always #5 clk = ~clk;

  eth_frame_detector_log_arbiter #(
    .C_AXIS_LOG_WIDTH (DW),
    .C_CNT_WIDTH      (CW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .clear_counters      (clear_counters),
    .s_axis_log_a_tdata  (a_data),
    .s_axis_log_a_tlast  (a_last),
    .s_axis_log_a_tvalid (a_valid),
    .s_axis_log_a_tready (a_ready),
    .s_axis_log_b_tdata  (b_data),
    .s_axis_log_b_tlast  (b_last),
    .s_axis_log_b_tvalid (b_valid),
    .s_axis_log_b_tready (b_ready),
    .m_axis_log_tdata    (m_data),
    .m_axis_log_tdest    (m_dest),
    .m_axis_log_tlast    (m_last),
    .m_axis_log_tvalid   (m_valid),
    .m_axis_log_tready   (m_ready),
    .count_a             (count_a),
    .count_b             (count_b),
    .busy                (busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst, en, av, al, bv, bl, mr;
    logic [7:0] ad, bd;
    bit         x_ar, x_br, x_mv, x_mdst, x_ml, x_busy;
    logic [7:0] x_md;
    int         x_ca, x_cb;
    bit         chk;
  } vec_t;

  function automatic vec_t mk(input bit r, en, av, input logic [7:0] ad, input bit al,
                              input bit bv, input logic [7:0] bd, input bit bl, input bit mr,
                              input bit ar, br, mv, input logic [7:0] md, input bit mdst, ml,
                              input bit bsy, input int ca, cb, input bit c);
    vec_t v;
    v.rst = r; v.en = en; v.av = av; v.ad = ad; v.al = al;
    v.bv = bv; v.bd = bd; v.bl = bl; v.mr = mr;
    v.x_ar = ar; v.x_br = br; v.x_mv = mv; v.x_md = md; v.x_mdst = mdst; v.x_ml = ml;
    v.x_busy = bsy; v.x_ca = ca; v.x_cb = cb; v.chk = c;
    return v;
  endfunction

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b0; clear_counters = 1'b0; m_ready = 1'b0;
    a_valid = 1'b0; a_last = 1'b0; a_data = '0;
    b_valid = 1'b0; b_last = 1'b0; b_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  // Single-beat packet from A; optionally pulses clear_counters on the accept cycle.
  task automatic send_pkt_a(input logic [DW-1:0] d, input bit clr, output bit ok);
    ok = 1'b0;
    a_valid = 1'b1; a_data = d; a_last = 1'b1;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (a_ready) begin
        ok = 1'b1;
        clear_counters = clr;
      end
      cyc();
    end
    a_valid = 1'b0; a_last = 1'b0; clear_counters = 1'b0;
  endtask

  vec_t          tbl[$];
  logic [127:0]  act, exp;
  logic [DW-1:0] rx[8];
  int            nrx, beat;
  bit            acc, ok, prev_stall;
  logic [DW-1:0] prev_d;
  logic          prev_dst, prev_l;

  beat_t         exp_q[2][$];
  bit            sv[2], sl[2], sacc[2];
  logic [DW-1:0] sd[2];
  int            rem[2], mc[2];
  bit            gen, in_pkt;
  logic          cur_dest;
  beat_t         eb;

  initial begin
    // ---------------- reset values ----------------
    do_reset();
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_out", {m_data, m_dest, m_last}, 0);
    chk("rst_count_a", count_a, 0);
    chk("rst_count_b", count_b, 0);
    chk("rst_busy", busy, 0);
    cyc();

    // ---------------- vector table ----------------
    // Lone 3-beat A packet, full downstream throughput.
    tbl.push_back(mk(0,1, 1,8'h11,0, 0,0,0, 1,  0,0,0,8'h00,0,0, 0, 0,0, 1));
    tbl.push_back(mk(0,1, 1,8'h11,0, 0,0,0, 1,  1,0,0,8'h00,0,0, 1, 0,0, 1));
    tbl.push_back(mk(0,1, 1,8'h22,0, 0,0,0, 1,  1,0,1,8'h11,0,0, 1, 0,0, 1));
    tbl.push_back(mk(0,1, 1,8'h33,1, 0,0,0, 1,  1,0,1,8'h22,0,0, 1, 0,0, 1));
    tbl.push_back(mk(0,1, 0,8'h00,0, 0,0,0, 1,  0,0,1,8'h33,0,1, 1, 1,0, 1));
    tbl.push_back(mk(0,1, 0,8'h00,0, 0,0,0, 1,  0,0,0,8'h00,0,0, 0, 1,0, 1));
    // Reset, then simultaneous A/B requests: A, B, A, B in strict rotation.
    tbl.push_back(mk(1,0, 0,8'h00,0, 0,0,0, 1,  0,0,0,8'h00,0,0, 0, 0,0, 0));
    tbl.push_back(mk(0,1, 1,8'hA1,0, 1,8'hB1,0, 1,  0,0,0,8'h00,0,0, 0, 0,0, 1));
    tbl.push_back(mk(0,1, 1,8'hA1,0, 1,8'hB1,0, 1,  1,0,0,8'h00,0,0, 1, 0,0, 1));
    tbl.push_back(mk(0,1, 1,8'hA2,1, 1,8'hB1,0, 1,  1,0,1,8'hA1,0,0, 1, 0,0, 1));
    tbl.push_back(mk(0,1, 1,8'hA3,1, 1,8'hB1,0, 1,  0,0,1,8'hA2,0,1, 1, 1,0, 1));
    tbl.push_back(mk(0,1, 1,8'hA3,1, 1,8'hB1,0, 1,  0,1,0,8'h00,0,0, 1, 1,0, 1));
    tbl.push_back(mk(0,1, 1,8'hA3,1, 1,8'hB2,1, 1,  0,1,1,8'hB1,1,0, 1, 1,0, 1));
    tbl.push_back(mk(0,1, 1,8'hA3,1, 1,8'hB3,1, 1,  0,0,1,8'hB2,1,1, 1, 1,1, 1));
    tbl.push_back(mk(0,1, 1,8'hA3,1, 1,8'hB3,1, 1,  1,0,0,8'h00,0,0, 1, 1,1, 1));
    tbl.push_back(mk(0,1, 0,8'h00,0, 1,8'hB3,1, 1,  0,0,1,8'hA3,0,1, 1, 2,1, 1));
    tbl.push_back(mk(0,1, 0,8'h00,0, 1,8'hB3,1, 1,  0,1,0,8'h00,0,0, 1, 2,1, 1));
    tbl.push_back(mk(0,1, 0,8'h00,0, 0,0,0, 1,  0,0,1,8'hB3,1,1, 1, 2,2, 1));
    tbl.push_back(mk(0,1, 0,8'h00,0, 0,0,0, 1,  0,0,0,8'h00,0,0, 0, 2,2, 1));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; enable = tbl[i].en; m_ready = tbl[i].mr;
      a_valid = tbl[i].av; a_data = {56'd0, tbl[i].ad}; a_last = tbl[i].al;
      b_valid = tbl[i].bv; b_data = {56'd0, tbl[i].bd}; b_last = tbl[i].bl;
      @(negedge clk);
      if (tbl[i].chk) begin
        act = {a_ready, b_ready, m_valid, busy, count_a, count_b,
               (m_valid ? {m_data, m_dest, m_last} : 66'd0)};
        exp = {tbl[i].x_ar, tbl[i].x_br, tbl[i].x_mv, tbl[i].x_busy,
               CW'(tbl[i].x_ca), CW'(tbl[i].x_cb),
               (tbl[i].x_mv ? {56'd0, tbl[i].x_md, tbl[i].x_mdst, tbl[i].x_ml} : 66'd0)};
        chk($sformatf("vec[%0d]", i), act, exp);
      end
      cyc();
    end
    rst = 1'b0;

    // ---------------- downstream stall, 4-beat A packet ----------------
    do_reset();
    enable = 1'b1;
    beat = 0; nrx = 0; prev_stall = 1'b0;
    for (int k = 0; k < 40; k++) begin
      a_valid = (beat < 4); a_data = 64'h41 + beat; a_last = (beat == 3);
      m_ready = ((k % 4) == 0) || ((k % 4) == 3);
      @(negedge clk);
      acc = a_valid && a_ready;
      if (m_valid && !m_ready) chk("stall_a_ready", a_ready, 0);
      if (prev_stall) chk("stall_hold", {m_valid, m_data, m_dest, m_last}, {1'b1, prev_d, prev_dst, prev_l});
      if (m_valid && m_ready) begin
        if (nrx < 8) rx[nrx] = m_data;
        nrx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data; prev_dst = m_dest; prev_l = m_last;
      cyc();
      if (acc) beat++;
    end
    chk("stall_nbeats", nrx, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("stall_beat[%0d]", i), rx[i], 64'h41 + i);
    chk("stall_count_a", count_a, 1);

    // ---------------- enable dropped mid-packet ----------------
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    b_valid = 1'b1; b_data = 64'hB1; b_last = 1'b0;
    cyc();
    cyc();
    b_data = 64'hB2; enable = 1'b0;
    a_valid = 1'b1; a_data = 64'hA1; a_last = 1'b1;
    cyc();
    b_data = 64'hB3; b_last = 1'b1;
    cyc();
    b_valid = 1'b0; b_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("en_low_a_ready", a_ready, 0);
      chk("en_low_counts", {count_a, count_b}, {CW'(0), CW'(1)});
      cyc();
    end
    chk("en_low_busy", busy, 0);
    enable = 1'b1;
    cyc();
    @(negedge clk);
    chk("en_high_a_ready", a_ready, 1);
    cyc();
    a_valid = 1'b0; a_last = 1'b0;
    @(negedge clk);
    chk("en_high_out", {m_valid, m_data, m_dest, m_last}, {1'b1, 64'hA1, 1'b0, 1'b1});
    chk("en_high_count_a", count_a, 1);
    cyc();

    // ---------------- saturation and clear priority ----------------
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      send_pkt_a(64'h50 + p, p == 4, ok);
      chk("sat_accept", ok, 1);
      @(negedge clk);
      chk($sformatf("sat_count[%0d]", p), count_a, (p == 4) ? 0 : ((p + 1 > CNTMAX) ? CNTMAX : p + 1));
    end

    // ---------------- reset mid-packet ----------------
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    a_valid = 1'b1; a_data = 64'h61; a_last = 1'b0;
    cyc();
    cyc();
    a_data = 64'h62;
    cyc();
    a_data = 64'h63; rst = 1'b1;
    cyc();
    rst = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", {m_valid, m_data, m_dest, m_last}, 0);
    chk("mid_rst_ready", {a_ready, b_ready}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count_a", count_a, 0);
    send_pkt_a(64'h70, 1'b0, ok);
    chk("post_rst_accept", ok, 1);
    @(negedge clk);
    chk("post_rst_out", {m_valid, m_data, m_dest, m_last}, {1'b1, 64'h70, 1'b0, 1'b1});
    chk("post_rst_count_a", count_a, 1);

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    for (int s = 0; s < 2; s++) begin
      sv[s] = 0; sl[s] = 0; sd[s] = '0; rem[s] = 0; mc[s] = 0; sacc[s] = 0;
    end
    in_pkt = 0; cur_dest = 0; prev_stall = 0;
    for (int c = 0; c < 3080; c++) begin
      gen = (c < 3000);
      for (int s = 0; s < 2; s++) begin
        if (sacc[s]) sv[s] = 0;
        if (!sv[s] && ((rem[s] > 0 && (!gen || $urandom_range(0, 3) != 0)) ||
                       (rem[s] == 0 && gen && $urandom_range(0, 2) == 0))) begin
          if (rem[s] == 0) rem[s] = $urandom_range(1, 4);
          sd[s] = {$urandom, $urandom};
          sl[s] = (rem[s] == 1);
          rem[s]--;
          sv[s] = 1;
          exp_q[s].push_back({sd[s], sl[s]});
        end
      end
      a_valid = sv[0]; a_data = sd[0]; a_last = sl[0];
      b_valid = sv[1]; b_data = sd[1]; b_last = sl[1];
      enable         = gen ? ($urandom_range(0, 7) != 0) : 1'b1;
      m_ready        = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      clear_counters = gen && ($urandom_range(0, 29) == 0);
      @(negedge clk);
      sacc[0] = a_valid && a_ready;
      sacc[1] = b_valid && b_ready;
      chk("rand_count_a", count_a, mc[0]);
      chk("rand_count_b", count_b, mc[1]);
      for (int s = 0; s < 2; s++) begin
        if (clear_counters) mc[s] = 0;
        else if (sacc[s] && sl[s]) mc[s] = (mc[s] < CNTMAX) ? mc[s] + 1 : CNTMAX;
      end
      if (prev_stall) chk("rand_hold", {m_valid, m_data, m_dest, m_last}, {1'b1, prev_d, prev_dst, prev_l});
      if (m_valid && m_ready) begin
        if (in_pkt) chk("rand_no_interleave", m_dest, cur_dest);
        if (exp_q[m_dest].size() == 0) begin
          chk("rand_unexpected_beat", 1'b1, 1'b0);
        end else begin
          eb = exp_q[m_dest].pop_front();
          chk("rand_beat", {m_data, m_last}, eb);
        end
        in_pkt = !m_last;
        cur_dest = m_dest;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data; prev_dst = m_dest; prev_l = m_last;
      cyc();
    end
    chk("rand_drain_a", exp_q[0].size(), 0);
    chk("rand_drain_b", exp_q[1].size(), 0);
    chk("rand_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
